uart_rx_fifo: RTL

Receive-side byte buffer between the UART receiver and the bus-facing UART register block. It captures each byte pulse from the receiver (valid/data/error) into a circular FIFO, so software reads are decoupled from line timing. It exposes first-word-fall-through read data, occupancy and sticky error flags to the register block, replacing the single-byte receive holding register.

---
 rtl/uart_rx_fifo.sv | 74 +++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the UART receiver and the register block: FWFT head, occupancy, sticky errors.
// Optional interrupt output is built only when UART_RX_FIFO_IRQ_EN is defined.
module uart_rx_fifo #(
  parameter int DEPTH         = 16,
  parameter int IRQ_THRESHOLD = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_rx_valid,
  input  logic [7:0]               i_rx_data,
  input  logic                     i_rx_error,
  input  logic                     i_pop,
  output logic [7:0]               o_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic                     o_frame_err,
  input  logic                     i_clear_err,
  output logic                     o_irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          pop_ok, push_ok, drop;
  logic          ovf_next, ferr_next;

  assign o_empty = (count == '0);
  assign o_full  = (count == CW'(DEPTH));
  assign o_count = count;
  assign o_data  = o_empty ? 8'h00 : mem[rd_ptr];

  // A pop in the same cycle frees the slot, so a full FIFO can still accept the byte.
  assign pop_ok  = i_pop & ~o_empty;
  assign push_ok = i_rx_valid & ~i_rx_error & (~o_full | pop_ok);
  assign drop    = i_rx_valid & ~i_rx_error & o_full & ~pop_ok;

  assign count_next = count + CW'(push_ok) - CW'(pop_ok);
  assign ovf_next   = drop | (o_overflow & ~i_clear_err);
  assign ferr_next  = i_rx_error | (o_frame_err & ~i_clear_err);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= i_rx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_overflow  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count       <= count_next;
      o_overflow  <= ovf_next;
      o_frame_err <= ferr_next;
    end
  end

`ifdef UART_RX_FIFO_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) o_irq <= 1'b0;
    else       o_irq <= (count_next >= CW'(IRQ_THRESHOLD)) | ovf_next | ferr_next;
  end
`else
  assign o_irq = 1'b0;
`endif

endmodule
